// File: rtl/mpaddsub_pkg.sv
// Shared definitions for the multiprecision adder/subtractor: op encodings,
// limb-count helper and FSM state encoding.
package mp_pkg;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_RSUB = 2'b10;
    localparam logic [1:0] OP_ADC  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mp_state_e;

    function automatic int mp_cycles(input int width, input int chunk);
        return (width + chunk - 1) / chunk;
    endfunction

endpackage

// File: rtl/mpaddsub_if.sv
// Operand/result handshake bundle: master drives operands and takes results,
// slave is the adder/subtractor.
interface mpaddsub_if #(
    parameter int WIDTH = 1027
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   result;
    logic             busy;

    modport master (
        output in_valid, op, in_a, in_b, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  in_valid, op, in_a, in_b, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface

// File: rtl/mpaddsub_limb_add.sv
// One limb of the multiprecision datapath: CHUNK-bit add with carry in/out;
// B is optionally inverted, but only on the bits selected by i_mask.
module mp_limb_add #(
    parameter int CHUNK = 257
) (
    input  logic [CHUNK-1:0] i_a,
    input  logic [CHUNK-1:0] i_b,
    input  logic             i_cin,
    input  logic             i_inv,
    input  logic [CHUNK-1:0] i_mask,
    output logic [CHUNK-1:0] o_sum,
    output logic             o_cout
);
    logic [CHUNK-1:0] w_b;

    // Pad bits must stay zero so the carry out of bit WIDTH-1 lands in them.
    assign w_b = i_inv ? (i_b ^ i_mask) : i_b;

    assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, w_b} + {{CHUNK{1'b0}}, i_cin};
endmodule

// File: rtl/mpaddsub.sv
// Multi-cycle multiprecision add/sub/rsub/adc: one CHUNK-bit limb per cycle,
// registered carry between limbs, valid/ready on both sides.
module mpaddsub
    import mp_pkg::*;
#(
    parameter int WIDTH = 1027,
    parameter int CHUNK = 257
) (
    input  logic       clk,
    input  logic       resetn,
    mpaddsub_if.slave  bus
);
    localparam int CYCLES = mp_cycles(WIDTH, CHUNK);
    localparam int EXT    = CYCLES * CHUNK;
    localparam int CNT_W  = $clog2(CYCLES) + 1;

    typedef logic [EXT-1:0] ext_t;

    localparam ext_t             VALID_MASK = {EXT{1'b1}} >> (EXT - WIDTH);
    localparam logic [CHUNK-1:0] LAST_MASK  = VALID_MASK[EXT-1 -: CHUNK];

    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_RUN  = ST_RUN;
    localparam logic [1:0] S_DONE = ST_DONE;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_carry;
    logic             r_inv;
    ext_t             r_a;
    ext_t             r_b;
    ext_t             r_res;

    logic             w_accept;
    logic             w_last;
    logic [CHUNK-1:0] w_mask;
    logic [CHUNK-1:0] w_limb;
    logic             w_cout;
    ext_t             w_res_next;
    logic             w_flag;

    assign bus.in_ready  = (r_state == S_IDLE) || ((r_state == S_DONE) && bus.out_ready);
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.busy      = (r_state == S_RUN);
    assign bus.result    = {w_flag, r_res[WIDTH-1:0]};

    assign w_accept = bus.in_valid && bus.in_ready;
    assign w_last   = (r_cnt == CNT_W'(CYCLES - 1));
    assign w_mask   = w_last ? LAST_MASK : '1;

    mp_limb_add #(.CHUNK(CHUNK)) u_limb (
        .i_a    (r_a[CHUNK-1:0]),
        .i_b    (r_b[CHUNK-1:0]),
        .i_cin  (r_carry),
        .i_inv  (r_inv),
        .i_mask (w_mask),
        .o_sum  (w_limb),
        .o_cout (w_cout)
    );

    // Limbs enter at the top so the least significant one ends up at bit 0.
    generate
        if (EXT > CHUNK) begin : g_shift
            assign w_res_next = {w_limb, r_res[EXT-1:CHUNK]};
        end else begin : g_single
            assign w_res_next = w_limb;
        end

        if (EXT > WIDTH) begin : g_flag_pad
            assign w_flag = r_res[WIDTH];
        end else begin : g_flag_carry
            assign w_flag = r_carry;
        end
    endgenerate

    // NOTE: state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_inv   <= 1'b0;
            r_res   <= '0;
        end else if (w_accept) begin
            r_state <= S_RUN;
            r_cnt   <= '0;
            r_carry <= (bus.op != OP_ADD);
            r_inv   <= (bus.op == OP_SUB) || (bus.op == OP_RSUB);
        end else begin
            case (r_state)
                S_RUN: begin
                    r_res   <= w_res_next;
                    r_carry <= w_cout;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                S_IDLE: ;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // NOTE: operand shift registers have no reset; they are always loaded on accept before use.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_a <= (bus.op == OP_RSUB) ? ext_t'(bus.in_b) : ext_t'(bus.in_a);
            r_b <= (bus.op == OP_RSUB) ? ext_t'(bus.in_a) : ext_t'(bus.in_b);
        end else if (r_state == S_RUN) begin
            r_a <= r_a >> CHUNK;
            r_b <= r_b >> CHUNK;
        end
    end
endmodule

// File: tb/tb_mpaddsub.sv
// Self-checking bench: directed vectors and corner sequences on the default
// configuration, plus randomised sweeps of three other configurations.
module tb_mpaddsub;
    import mp_pkg::*;

    localparam int W0    = 1027;
    localparam int C0    = 257;
    localparam int CW    = W0 + 1;
    localparam int N_OPS = 1000;

    logic clk = 1'b0;
    logic resetn;
    bit   sweep_go = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: no response within bound", name);
    endtask

    // ---------------- default configuration, directed ----------------
    mpaddsub_if #(.WIDTH(W0)) bus0 ();

    mpaddsub #(.WIDTH(W0), .CHUNK(C0)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus0)
    );

    typedef struct {
        logic [1:0]    op;
        logic [W0-1:0] a;
        logic [W0-1:0] b;
        logic [W0:0]   exp;
    } vec_t;

    vec_t        vecs[12];
    logic [W0:0] q0[$];

    task automatic send0(input logic [1:0] op, input logic [W0-1:0] a, input logic [W0-1:0] b,
                         input logic [W0:0] exp);
        int t = 0;
        @(negedge clk);
        bus0.in_valid = 1'b1;
        bus0.op       = op;
        bus0.in_a     = a;
        bus0.in_b     = b;
        #1;
        while (!bus0.in_ready && t < 100) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (!bus0.in_ready) begin
            timeout_fail("send in_ready");
        end else begin
            q0.push_back(exp);
            @(posedge clk);
            #1;
        end
        bus0.in_valid = 1'b0;
    endtask

    task automatic recv0(input string name);
        int t = 0;
        logic [W0:0] exp;
        @(negedge clk);
        #1;
        while (!bus0.out_valid && t < 100) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (!bus0.out_valid || q0.size() == 0) begin
            timeout_fail(name);
        end else begin
            bus0.out_ready = 1'b1;
            #1;
            exp = q0.pop_front();
            check(name, bus0.result, exp);
            @(posedge clk);
            #1;
            bus0.out_ready = 1'b0;
        end
    endtask

    // Counts rising edges from just after an accept edge until out_valid shows.
    task automatic measure_latency(input string name, input int want);
        int n = 0;
        while (!bus0.out_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, CW'(n), CW'(want));
    endtask

    initial begin
        logic [W0-1:0] ones;
        logic [W0-1:0] limb_ones;
        logic [W0-1:0] limb_bit;
        logic [W0:0]   exp;
        int            t;

        ones      = '1;
        limb_bit  = W0'(1) << C0;
        limb_ones = limb_bit - W0'(1);

        vecs[0]  = '{OP_ADD,  ones,       W0'(1), {1'b1, W0'(0)}};
        vecs[1]  = '{OP_SUB,  W0'(5),     W0'(7), {1'b0, ones - W0'(1)}};
        vecs[2]  = '{OP_SUB,  W0'(7),     W0'(5), {1'b1, W0'(2)}};
        vecs[3]  = '{OP_RSUB, W0'(5),     W0'(7), {1'b1, W0'(2)}};
        vecs[4]  = '{OP_ADC,  W0'(3),     W0'(4), {1'b0, W0'(8)}};
        vecs[5]  = '{OP_ADD,  W0'(0),     W0'(0), {1'b0, W0'(0)}};
        vecs[6]  = '{OP_SUB,  W0'(0),     W0'(0), {1'b1, W0'(0)}};
        vecs[7]  = '{OP_ADC,  ones,       ones,   {1'b1, ones}};
        vecs[8]  = '{OP_RSUB, W0'(7),     W0'(5), {1'b0, ones - W0'(1)}};
        vecs[9]  = '{OP_ADD,  limb_ones,  W0'(1), {1'b0, limb_bit}};
        vecs[10] = '{OP_SUB,  limb_bit,   W0'(1), {1'b1, limb_ones}};
        vecs[11] = '{OP_SUB,  W0'(0),     W0'(1), {1'b0, ones}};

        bus0.in_valid  = 1'b0;
        bus0.op        = OP_ADD;
        bus0.in_a      = '0;
        bus0.in_b      = '0;
        bus0.out_ready = 1'b0;
        resetn         = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        check("reset in_ready",  CW'(bus0.in_ready),  CW'(1));
        check("reset out_valid", CW'(bus0.out_valid), CW'(0));
        check("reset busy",      CW'(bus0.busy),      CW'(0));
        check("reset result",    bus0.result,         '0);
        resetn = 1'b1;

        for (int i = 0; i < 12; i++) begin
            send0(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);
            if (i == 0) begin
                measure_latency("latency vec0", 4);
            end
            recv0($sformatf("vec%0d", i));
        end

        // Back-pressure: result held, in_valid ignored until out_ready returns.
        send0(OP_ADD, W0'(10), W0'(20), {1'b0, W0'(30)});
        t = 0;
        while (!bus0.out_valid && t < 100) begin
            @(negedge clk);
            #1;
            t++;
        end
        bus0.in_valid = 1'b1;
        bus0.op       = OP_SUB;
        bus0.in_a     = W0'(100);
        bus0.in_b     = W0'(1);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            #1;
            check("hold result",    bus0.result,          {1'b0, W0'(30)});
            check("hold out_valid", CW'(bus0.out_valid),  CW'(1));
            check("hold in_ready",  CW'(bus0.in_ready),   CW'(0));
            check("hold busy",      CW'(bus0.busy),       CW'(0));
        end
        @(negedge clk);
        bus0.out_ready = 1'b1;
        #1;
        check("release in_ready", CW'(bus0.in_ready), CW'(1));
        if (q0.size() == 0) begin
            timeout_fail("release scoreboard");
        end else begin
            exp = q0.pop_front();
            check("release result", bus0.result, exp);
        end
        q0.push_back({1'b1, W0'(99)});
        @(posedge clk);
        #1;
        bus0.out_ready = 1'b0;
        bus0.in_valid  = 1'b0;
        check("b2b busy", CW'(bus0.busy), CW'(1));
        measure_latency("b2b latency", 4);
        recv0("b2b result");

        // Reset two cycles into RUN drops the operation immediately.
        send0(OP_ADD, ones, ones, {1'b1, ones - W0'(1)});
        @(posedge clk);
        @(posedge clk);
        #1;
        check("run busy",     CW'(bus0.busy),     CW'(1));
        check("run in_ready", CW'(bus0.in_ready), CW'(0));
        resetn = 1'b0;
        #1;
        check("midrun out_valid", CW'(bus0.out_valid), CW'(0));
        check("midrun result",    bus0.result,         '0);
        check("midrun busy",      CW'(bus0.busy),      CW'(0));
        check("midrun in_ready",  CW'(bus0.in_ready),  CW'(1));
        q0.delete();
        @(negedge clk);
        resetn = 1'b1;
        send0(OP_ADD, W0'(1), W0'(1), {1'b0, W0'(2)});
        measure_latency("cold latency", 4);
        recv0("after reset");

        sweep_go = 1'b1;
        t = 0;
        while (!(g_sweep[0].done_g && g_sweep[1].done_g && g_sweep[2].done_g) && t < 80000) begin
            @(negedge clk);
            t++;
        end
        if (!(g_sweep[0].done_g && g_sweep[1].done_g && g_sweep[2].done_g)) begin
            timeout_fail("sweeps");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // ---------------- randomised configuration sweeps ----------------
    for (genvar g = 0; g < 3; g++) begin : g_sweep
        localparam int W = (g == 2) ? 16 : 1027;
        localparam int C = (g == 0) ? 1027 : ((g == 1) ? 100 : 4);

        mpaddsub_if #(.WIDTH(W)) bus ();

        mpaddsub #(.WIDTH(W), .CHUNK(C)) dut (
            .clk    (clk),
            .resetn (resetn),
            .bus    (bus)
        );

        logic [W:0] q[$];
        bit         done_g = 1'b0;

        function automatic logic [W:0] model(input logic [1:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
            logic [W:0] r;
            case (op)
                OP_ADD:  r = {1'b0, a} + {1'b0, b};
                OP_SUB:  r = {a >= b, a - b};
                OP_RSUB: r = {b >= a, b - a};
                default: r = {1'b0, a} + {1'b0, b} + (W + 1)'(1);
            endcase
            return r;
        endfunction

        function automatic logic [W-1:0] edge_val(input int k);
            logic [W-1:0] v;
            case (k)
                0:       v = '0;
                1:       v = W'(1);
                default: v = '1;
            endcase
            return v;
        endfunction

        function automatic logic [W-1:0] rand_val();
            logic [W+31:0] v = '0;
            for (int i = 0; i < W; i += 32) begin
                v[i +: 32] = $urandom();
            end
            return v[W-1:0];
        endfunction

        initial begin
            logic [1:0]   op;
            logic [W-1:0] a;
            logic [W-1:0] b;
            int           t;
            bus.in_valid = 1'b0;
            bus.op       = OP_ADD;
            bus.in_a     = '0;
            bus.in_b     = '0;
            wait (sweep_go);
            for (int n = 0; n < N_OPS; n++) begin
                if (n < 36) begin
                    op = 2'(n % 4);
                    a  = edge_val((n / 4) % 3);
                    b  = edge_val(n / 12);
                end else begin
                    op = 2'($urandom_range(0, 3));
                    a  = ($urandom_range(0, 7) == 0) ? edge_val(int'($urandom_range(0, 2))) : rand_val();
                    b  = ($urandom_range(0, 7) == 0) ? edge_val(int'($urandom_range(0, 2))) : rand_val();
                end
                @(negedge clk);
                bus.in_valid = 1'b1;
                bus.op       = op;
                bus.in_a     = a;
                bus.in_b     = b;
                #1;
                t = 0;
                while (!bus.in_ready && t < 200) begin
                    @(negedge clk);
                    #1;
                    t++;
                end
                if (!bus.in_ready) begin
                    timeout_fail($sformatf("sweep%0d in_ready", g));
                    bus.in_valid = 1'b0;
                    break;
                end
                q.push_back(model(op, a, b));
                @(posedge clk);
                #1;
                bus.in_valid = 1'b0;
            end
        end

        initial begin
            bus.out_ready = 1'b0;
            wait (sweep_go);
            while (!done_g) begin
                @(negedge clk);
                bus.out_ready = ($urandom_range(0, 3) != 0);
            end
            bus.out_ready = 1'b0;
        end

        initial begin
            int         t;
            int         n_got;
            logic [W:0] exp_r;
            n_got = 0;
            wait (sweep_go);
            t = 0;
            while (n_got < N_OPS && t < 40000) begin
                @(negedge clk);
                #2;
                t++;
                if (bus.out_valid && bus.out_ready) begin
                    if (q.size() == 0) begin
                        timeout_fail($sformatf("sweep%0d unexpected result", g));
                        break;
                    end
                    exp_r = q.pop_front();
                    check($sformatf("sweep%0d op%0d", g, n_got), CW'(bus.result), CW'(exp_r));
                    n_got++;
                end
            end
            if (n_got < N_OPS) begin
                timeout_fail($sformatf("sweep%0d results", g));
            end
            done_g = 1'b1;
        end
    end
endmodule
